// File: rtl/uart_iq_cmd_rx.sv
// UART receiver plus signed-decimal command parser for the q-axis target.
// Each CR/LF-terminated number updates the clamped o_iq_aim and pulses o_en.
module uart_iq_cmd_rx #(
  parameter logic [15:0] CLK_DIV  = 16'd320,
  parameter logic [15:0] IQ_LIMIT = 16'd1000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        i_uart_rx,
  output logic [15:0] o_iq_aim,
  output logic        o_en,
  output logic        o_err
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_t;
  typedef enum logic [1:0] {P_IDLE, P_SIGN, P_DIG, P_ERR} ps_t;

  logic        s1, s2, s3;
  rx_t         rx_st, rx_nx;
  logic [15:0] cnt, cnt_nx;
  logic [2:0]  bidx, bidx_nx;
  logic [7:0]  sh, sh_nx;
  logic        byte_ok, frm_err, fall, expire;

  ps_t         ps, ps_nx;
  logic        neg, neg_nx;
  logic [16:0] acc, acc_nx, dig, mag;
  logic [2:0]  nd, nd_nx;
  logic [15:0] aim_nx;
  logic        en_nx, err_nx, bad;
  logic        go, is_dig, is_term, is_sp, is_sgn;

  assign fall   = s3 & ~s2;
  assign expire = (cnt == 16'd1);

  always_comb begin
    rx_nx   = rx_st;
    cnt_nx  = cnt;
    bidx_nx = bidx;
    sh_nx   = sh;
    byte_ok = 1'b0;
    frm_err = 1'b0;
    if (rx_st != IDLE) cnt_nx = cnt - 16'd1;
    unique case (rx_st)
      IDLE: if (fall) begin
        rx_nx  = START;
        cnt_nx = CLK_DIV >> 1;
      end
      START: if (expire) begin
        if (s2) begin
          rx_nx = IDLE;
        end else begin
          rx_nx   = DATA;
          cnt_nx  = CLK_DIV;
          bidx_nx = 3'd0;
        end
      end
      DATA: if (expire) begin
        sh_nx   = {s2, sh[7:1]};
        cnt_nx  = CLK_DIV;
        bidx_nx = bidx + 3'd1;
        if (bidx == 3'd7) rx_nx = STOP;
      end
      STOP: if (expire) begin
        rx_nx   = IDLE;
        byte_ok = s2;
        frm_err = ~s2;
      end
    endcase
  end

  // A framing error drives the parser like a byte that matches no class
  assign go      = byte_ok | frm_err;
  assign is_dig  = byte_ok && sh >= 8'h30 && sh <= 8'h39;
  assign is_term = byte_ok && (sh == 8'h0d || sh == 8'h0a);
  assign is_sp   = byte_ok && sh == 8'h20;
  assign is_sgn  = byte_ok && (sh == 8'h2d || sh == 8'h2b);
  assign dig     = {13'd0, sh[3:0]};
  assign mag     = (acc > {1'b0, IQ_LIMIT}) ? {1'b0, IQ_LIMIT} : acc;

  always_comb begin
    ps_nx  = ps;
    neg_nx = neg;
    acc_nx = acc;
    nd_nx  = nd;
    aim_nx = o_iq_aim;
    en_nx  = 1'b0;
    err_nx = 1'b0;
    bad    = 1'b0;
    if (go) begin
      unique case (ps)
        P_IDLE: if (is_sgn) begin
          neg_nx = (sh == 8'h2d);
          acc_nx = 17'd0;
          nd_nx  = 3'd0;
          ps_nx  = P_SIGN;
        end else if (is_dig) begin
          neg_nx = 1'b0;
          acc_nx = dig;
          nd_nx  = 3'd1;
          ps_nx  = P_DIG;
        end else if (!(is_term || is_sp)) begin
          bad = 1'b1;
        end
        P_SIGN: if (is_dig) begin
          acc_nx = dig;
          nd_nx  = 3'd1;
          ps_nx  = P_DIG;
        end else begin
          bad = 1'b1;
        end
        P_DIG: if (is_dig && nd < 3'd5) begin
          acc_nx = (acc << 3) + (acc << 1) + dig;
          nd_nx  = nd + 3'd1;
        end else if (is_term) begin
          ps_nx  = P_IDLE;
          en_nx  = 1'b1;
          aim_nx = neg ? 16'd0 - mag[15:0] : mag[15:0];
        end else begin
          bad = 1'b1;
        end
        P_ERR: if (is_term) ps_nx = P_IDLE;
      endcase
      if (bad) begin
        err_nx = 1'b1;
        ps_nx  = is_term ? P_IDLE : P_ERR;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1       <= 1'b1;
      s2       <= 1'b1;
      s3       <= 1'b1;
      rx_st    <= IDLE;
      cnt      <= 16'd0;
      bidx     <= 3'd0;
      sh       <= 8'd0;
      ps       <= P_IDLE;
      neg      <= 1'b0;
      acc      <= 17'd0;
      nd       <= 3'd0;
      o_iq_aim <= 16'd0;
      o_en     <= 1'b0;
      o_err    <= 1'b0;
    end else begin
      s1       <= i_uart_rx;
      s2       <= s1;
      s3       <= s2;
      rx_st    <= rx_nx;
      cnt      <= cnt_nx;
      bidx     <= bidx_nx;
      sh       <= sh_nx;
      ps       <= ps_nx;
      neg      <= neg_nx;
      acc      <= acc_nx;
      nd       <= nd_nx;
      o_iq_aim <= aim_nx;
      o_en     <= en_nx;
      o_err    <= err_nx;
    end
  end

endmodule
